flash_prog_cntrl: RTL
=====================

// Module: flash_prog_cntrl
// PURPOSE
//  Wishbone slave that writes the parallel NOR flash (Intel-style command set): word program,
//  block erase, status polling and single array reads, issued as timed WE#/OE# bus cycles.
//  It is the write-side counterpart to the read-only flash window controller and sits on the
//  same flash pads; the top level muxes pad ownership via busy_o. Used by the firmware updater.
// PARAMETERS
//  WE_CYC    4         clocks WE# held low per command/data write (also hold/gap after it)
//  RD_CYC    6         clocks OE# held low before sampling read data / status
//  POLL_MAX  24'hFFFFFF status reads allowed before abort with timeout flag
// PORTS
//  wb_clk_i     in   1   system clock, all logic on rising edge
//  wb_rst_i     in   1   synchronous active-high reset
//  wb_dat_i     in   16  Wishbone write data
//  wb_dat_o     out  16  Wishbone read data (registered)
//  wb_adr_i     in   2   register select, wb_adr_i[2:1]
//  wb_we_i      in   1   Wishbone write enable
//  wb_stb_i     in   1   Wishbone strobe
//  wb_cyc_i     in   1   Wishbone cycle
//  wb_ack_o     out  1   Wishbone acknowledge
//  flash_addr_  out  21  flash word address
//  flash_data_  inout 16 flash data bus, driven only in write phases
//  flash_we_n_  out  1   flash write strobe, active low
//  flash_oe_n_  out  1   flash output enable, active low
//  flash_ce2_   out  1   flash chip enable, active high
//  busy_o       out  1   operation in progress; top level grants pads to this block
// BEHAVIOUR
//  Reset: wb_ack_o=0, wb_dat_o=0, flash_we_n_=1, flash_oe_n_=1, flash_ce2_=0, data tristated,
//   flash_addr_=0, busy_o=0, all registers 0, FSM=IDLE.
//  Wishbone: wb_ack_o <= cyc&stb&~ack (one-cycle ack, 1 wait state); always acked, even busy.
//  Register map (adr[2:1]): 0 ADDR_LO rw [15:0]; 1 ADDR_HI rw [4:0] = addr[20:16];
//   2 DATA rw program data / read result; 3 CTRL: write bit0=PROG bit1=ERASE bit2=READ;
//   read {SR[7:0], 4'b0, tmo, err, done, busy}.
//  Writes to regs 0-3 while busy are ignored. CTRL write with >1 op bit or 0 bits is ignored.
//  CTRL write of an op: done/err/tmo cleared, busy=1 next cycle; read of CTRL clears done.
//  Bus cycle (write): ce2=1, addr/data stable 1 clk, we_n=0 WE_CYC clks, we_n=1 WE_CYC clks.
//  Bus cycle (read): ce2=1, oe_n=0 RD_CYC clks, sample flash_data_ on last, oe_n=1 1 clk.
//  FSM: IDLE -> CMD1 -> CMD2 -> POLL -> RESTORE -> IDLE; READ path IDLE -> CMD1 -> RDARR -> IDLE.
//   PROG:  CMD1 wr 16'h0040, CMD2 wr DATA at ADDR.  ERASE: CMD1 wr 16'h0020, CMD2 wr 16'h00D0.
//   POLL:  wr 16'h0070 once, then repeat read cycles until SR7=1 or POLL_MAX reads.
//   SR7=1: SR latched; err=|SR[5:3] or SR[1]; if err also wr 16'h0050 (clear status).
//   RESTORE: wr 16'h00FF (read array); then done=1, busy=0, ce2=0.
//   READ:  CMD1 wr 16'h00FF, RDARR read at ADDR -> DATA, done=1.
//  Timeout: poll counter hits POLL_MAX -> tmo=1, go to RESTORE (SR holds last read).
//  Data bus driven only while ce2=1 & oe_n=1 in write cycles; never drive while oe_n=0.
//  Reset mid-operation: pads go idle same cycle as reset edge; flash may remain in status mode,
//   software must issue READ before using the window controller.
//  Counters: WE/RD timers 8 bits, poll counter 24 bits, saturating; no wrap.
// STRUCTURE
//  flash_cmds.vh: command constants (CMD_PROG, CMD_ERASE, CMD_CONFIRM, CMD_RDSR, CMD_CLRSR,
//   CMD_RDARR), CTRL bit positions, FSM state encodings.
//  Sub-module flash_bus_cycle: start/rw/addr/wdata in, timed pad sequencing, rdata+done out;
//   top FSM sequences commands through it.
// TESTING (bench with behavioural flash model: 2^21 words, status SR7 after N reads)
//  1 PROG addr 21'h1_0004 data 16'hA55A, model busy 3 reads -> pad writes 0040,A55A,0070,00FF;
//    CTRL reads busy until done, SR=8'h80, err=0; model word = A55A.
//  2 ERASE addr 21'h0_8000 -> writes 0020,00D0; model block set to FFFF; done=1.
//  3 READ addr 21'h0_0010 (model 16'h1234) -> write 00FF, DATA reads 1234, done=1.
//  4 Model SR=8'hA0 (erase fail) -> err=1, extra 0050 write before 00FF.
//  5 POLL_MAX=8, model never ready -> exactly 8 status reads, tmo=1, 00FF issued, busy=0.
//  6 Write ADDR_LO/CTRL while busy -> ignored, still acked in 1 wait state; reset mid-PROG ->
//    we_n=oe_n=1, ce2=0, data tristated, busy_o=0 on the cycle after reset.

Source files
------------

// File: rtl/flash_prog_cntrl_pkg.sv
`timescale 1ns/1ps
// flash_prog_cntrl_pkg: shared widths, flash command set, register map,
// CTRL bit positions, FSM encodings and the bus-cycle request payload.
package flash_prog_cntrl_pkg;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TMR_W  = 8;
    localparam int unsigned POLL_W = 24;

    // Intel-style command set
    localparam logic [DATA_W-1:0] CMD_PROG    = 16'h0040;
    localparam logic [DATA_W-1:0] CMD_ERASE   = 16'h0020;
    localparam logic [DATA_W-1:0] CMD_CONFIRM = 16'h00D0;
    localparam logic [DATA_W-1:0] CMD_RDSR    = 16'h0070;
    localparam logic [DATA_W-1:0] CMD_CLRSR   = 16'h0050;
    localparam logic [DATA_W-1:0] CMD_RDARR   = 16'h00FF;

    // Register map (wb_adr_i)
    localparam logic [1:0] REG_ADDR_LO = 2'd0;
    localparam logic [1:0] REG_ADDR_HI = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // CTRL write bit positions
    localparam int unsigned CTRL_PROG  = 0;
    localparam int unsigned CTRL_ERASE = 1;
    localparam int unsigned CTRL_READ  = 2;

    typedef enum logic [1:0] {
        OP_PROG  = 2'd0,
        OP_ERASE = 2'd1,
        OP_READ  = 2'd2
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD1     = 3'd1,
        S_CMD2     = 3'd2,
        S_POLL_CMD = 3'd3,
        S_POLL_RD  = 3'd4,
        S_CLRSR    = 3'd5,
        S_RESTORE  = 3'd6,
        S_RDARR    = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        B_IDLE  = 3'd0,
        B_SETUP = 3'd1,
        B_WE    = 3'd2,
        B_GAP   = 3'd3,
        B_OE    = 3'd4,
        B_OEH   = 3'd5
    } bus_state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_req_t;

endpackage

// File: rtl/flash_prog_cntrl_bus_cycle.sv
`timescale 1ns/1ps
// flash_prog_cntrl_bus_cycle: runs one timed flash bus cycle per start pulse.
//  clk, rst    clock, synchronous active-high reset
//  start, req  launch a write (req.wr=1) or read cycle at req.addr
//  pad_rdata   flash data pads, sampled on the last OE# clock
//  addr, wdata registered pad address / write data
//  drive       write data may be driven onto the pads
//  we_n, oe_n  registered flash strobes
//  rdata, done read result and one-clock completion pulse
module flash_prog_cntrl_bus_cycle
    import flash_prog_cntrl_pkg::*;
#(
    parameter int unsigned WE_CYC = 4,
    parameter int unsigned RD_CYC = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  bus_req_t          req,
    input  logic [DATA_W-1:0] pad_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              drive,
    output logic              we_n,
    output logic              oe_n,
    output logic [DATA_W-1:0] rdata,
    output logic              done
);

    localparam logic [TMR_W-1:0] WE_LAST = TMR_W'(WE_CYC - 1);
    localparam logic [TMR_W-1:0] RD_LAST = TMR_W'(RD_CYC - 1);

    bus_state_e        state_q, state_d;
    logic [TMR_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rdata_d;
    logic              drive_d, we_n_d, oe_n_d, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= B_IDLE;
            cnt_q   <= '0;
            addr    <= '0;
            wdata   <= '0;
            drive   <= 1'b0;
            we_n    <= 1'b1;
            oe_n    <= 1'b1;
            rdata   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr    <= addr_d;
            wdata   <= wdata_d;
            drive   <= drive_d;
            we_n    <= we_n_d;
            oe_n    <= oe_n_d;
            rdata   <= rdata_d;
            done    <= done_d;
        end
    end

    // Strobe sequencing: setup clock, WE# low/high windows, or OE# low window plus one recovery clock
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + TMR_W'(1);
        addr_d  = addr;
        wdata_d = wdata;
        drive_d = drive;
        we_n_d  = we_n;
        oe_n_d  = oe_n;
        rdata_d = rdata;
        done_d  = 1'b0;
        case (state_q)
            B_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    addr_d  = req.addr;
                    wdata_d = req.data;
                    if (req.wr) begin
                        state_d = B_SETUP;
                        drive_d = 1'b1;
                    end else begin
                        state_d = B_OE;
                        oe_n_d  = 1'b0;
                    end
                end
            end
            B_SETUP: begin
                state_d = B_WE;
                we_n_d  = 1'b0;
                cnt_d   = '0;
            end
            B_WE: begin
                if (cnt_q == WE_LAST) begin
                    state_d = B_GAP;
                    we_n_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            B_GAP: begin
                // data stays driven after WE# rises for hold
                if (cnt_q == WE_LAST) begin
                    state_d = B_IDLE;
                    drive_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            B_OE: begin
                if (cnt_q == RD_LAST) begin
                    rdata_d = pad_rdata;
                    oe_n_d  = 1'b1;
                    state_d = B_OEH;
                end
            end
            B_OEH: begin
                state_d = B_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = B_IDLE;
        endcase
    end

endmodule

// File: rtl/flash_prog_cntrl.sv
`timescale 1ns/1ps
// flash_prog_cntrl: Wishbone slave issuing NOR flash program / erase / read
// command sequences with status polling.
//  wb_*        Wishbone slave (16-bit data, 2-bit register select)
//  flash_*_    flash pads: address, data (driven only in write phases), WE#, OE#, CE2
//  busy_o      operation in progress, used by the top level for pad ownership
module flash_prog_cntrl
    import flash_prog_cntrl_pkg::*;
#(
    parameter int unsigned       WE_CYC   = 4,
    parameter int unsigned       RD_CYC   = 6,
    parameter logic [POLL_W-1:0] POLL_MAX = 24'hFFFFFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [1:0]        wb_adr_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] flash_addr_,
    inout  wire  [DATA_W-1:0] flash_data_,
    output logic              flash_we_n_,
    output logic              flash_oe_n_,
    output logic              flash_ce2_,
    output logic              busy_o
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              issue_q, issue_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, dat_d, rd_c;
    logic [7:0]        sr_q, sr_d;
    logic [POLL_W-1:0] poll_q, poll_d, poll_inc_c;
    logic              done_q, done_d, err_q, err_d, tmo_q, tmo_d;
    logic              busy_d, ce2_d, ack_d, acc_c, wr_c;
    logic              bus_start_c, bus_done, bus_drive;
    bus_req_t          bus_req_c;
    logic [DATA_W-1:0] bus_rdata, bus_wdata;

    flash_prog_cntrl_bus_cycle #(.WE_CYC(WE_CYC), .RD_CYC(RD_CYC)) u_bus (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .start     (bus_start_c),
        .req       (bus_req_c),
        .pad_rdata (flash_data_),
        .addr      (flash_addr_),
        .wdata     (bus_wdata),
        .drive     (bus_drive),
        .we_n      (flash_we_n_),
        .oe_n      (flash_oe_n_),
        .rdata     (bus_rdata),
        .done      (bus_done)
    );

    // never drive the pads while the flash may be driving them
    assign flash_data_ = (bus_drive && flash_ce2_ && flash_oe_n_) ? bus_wdata : {DATA_W{1'bz}};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            op_q       <= OP_PROG;
            issue_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            sr_q       <= '0;
            poll_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            busy_o     <= 1'b0;
            flash_ce2_ <= 1'b0;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            issue_q    <= issue_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sr_q       <= sr_d;
            poll_q     <= poll_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            busy_o     <= busy_d;
            flash_ce2_ <= ce2_d;
            wb_ack_o   <= ack_d;
            wb_dat_o   <= dat_d;
        end
    end

    // Register read mux
    always_comb begin
        case (wb_adr_i)
            REG_ADDR_LO: rd_c = addr_q[15:0];
            REG_ADDR_HI: rd_c = DATA_W'(addr_q[ADDR_W-1:16]);
            REG_DATA:    rd_c = data_q;
            default:     rd_c = {sr_q, 4'b0000, tmo_q, err_q, done_q, busy_o};
        endcase
    end

    // Wishbone register access and operation sequencing
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        issue_d     = issue_q;
        addr_d      = addr_q;
        data_d      = data_q;
        sr_d        = sr_q;
        poll_d      = poll_q;
        done_d      = done_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        busy_d      = busy_o;
        ce2_d       = flash_ce2_;
        dat_d       = wb_dat_o;
        bus_start_c = 1'b0;
        bus_req_c   = '{wr: 1'b1, addr: addr_q, data: CMD_RDARR};
        poll_inc_c  = (poll_q == '1) ? poll_q : poll_q + POLL_W'(1);

        acc_c = wb_cyc_i & wb_stb_i & ~wb_ack_o;
        wr_c  = acc_c & wb_we_i & ~busy_o;
        ack_d = acc_c;

        if (acc_c && !wb_we_i) begin
            dat_d = rd_c;
            if (wb_adr_i == REG_CTRL) done_d = 1'b0;
        end

        if (wr_c) begin
            case (wb_adr_i)
                REG_ADDR_LO: addr_d[15:0]         = wb_dat_i;
                REG_ADDR_HI: addr_d[ADDR_W-1:16] = wb_dat_i[4:0];
                REG_DATA:    data_d               = wb_dat_i;
                default: begin
                    if ($onehot(wb_dat_i[2:0])) begin
                        if (wb_dat_i[CTRL_PROG])       op_d = OP_PROG;
                        else if (wb_dat_i[CTRL_ERASE]) op_d = OP_ERASE;
                        else                           op_d = OP_READ;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        tmo_d   = 1'b0;
                        busy_d  = 1'b1;
                        ce2_d   = 1'b1;
                        state_d = S_CMD1;
                        issue_d = 1'b1;
                    end
                end
            endcase
        end

        // each non-idle state issues exactly one bus cycle, then acts on its completion
        if (state_q != S_IDLE && issue_q) begin
            bus_start_c = 1'b1;
            issue_d     = 1'b0;
        end

        case (state_q)
            S_CMD1: begin
                case (op_q)
                    OP_PROG:  bus_req_c.data = CMD_PROG;
                    OP_ERASE: bus_req_c.data = CMD_ERASE;
                    default:  bus_req_c.data = CMD_RDARR;
                endcase
                if (bus_done) begin
                    state_d = (op_q == OP_READ) ? S_RDARR : S_CMD2;
                    issue_d = 1'b1;
                end
            end
            S_CMD2: begin
                bus_req_c.data = (op_q == OP_PROG) ? data_q : CMD_CONFIRM;
                if (bus_done) begin
                    state_d = S_POLL_CMD;
                    issue_d = 1'b1;
                end
            end
            S_POLL_CMD: begin
                bus_req_c.data = CMD_RDSR;
                if (bus_done) begin
                    poll_d  = '0;
                    state_d = S_POLL_RD;
                    issue_d = 1'b1;
                end
            end
            S_POLL_RD: begin
                bus_req_c.wr = 1'b0;
                if (bus_done) begin
                    sr_d    = bus_rdata[7:0];
                    poll_d  = poll_inc_c;
                    issue_d = 1'b1;
                    if (bus_rdata[7]) begin
                        err_d   = (|bus_rdata[5:3]) | bus_rdata[1];
                        state_d = ((|bus_rdata[5:3]) | bus_rdata[1]) ? S_CLRSR : S_RESTORE;
                    end else if (poll_inc_c >= POLL_MAX) begin
                        tmo_d   = 1'b1;
                        state_d = S_RESTORE;
                    end
                end
            end
            S_CLRSR: begin
                bus_req_c.data = CMD_CLRSR;
                if (bus_done) begin
                    state_d = S_RESTORE;
                    issue_d = 1'b1;
                end
            end
            S_RESTORE: begin
                if (bus_done) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ce2_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RDARR: begin
                bus_req_c.wr = 1'b0;
                if (bus_done) begin
                    data_d  = bus_rdata;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ce2_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
    end

endmodule
